// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend
//   Oversampling UART receive front end feeding the RX FIFO. The raw rx pin is
//   synchronised, the start bit is validated at its midpoint, data bits are
//   sampled mid-bit (LSB first) and the stop bit is checked. A good frame
//   produces a one-cycle data_valid strobe that pushes data_out into the FIFO.
//   A low stop bit produces a one-cycle frame_err strobe. An all-zero frame
//   with a low stop bit also raises break_det until the line returns high.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high
//   rx_in      asynchronous serial line, idle high
//   tick16     one-clk pulse at OVERSAMPLE x baud
//   data_out   last received byte (bits above DATA_BITS read 0)
//   data_valid one-clk strobe, data_out updated (FIFO push)
//   frame_err  one-clk strobe, stop bit sampled low
//   break_det  level, line held low through a whole frame
//   busy       high whenever the receiver is not idle
module uart_rx_frontend #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  input  logic       tick16,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       break_det,
  output logic       busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync_q;
  logic            rx_s;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            dv_q, dv_d;
  logic            fe_q, fe_d;
  logic            brk_q, brk_d;

  // Two-flop synchroniser; primed high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_in};
    end
  end

  assign rx_s = sync_q[1];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      dv_q      <= 1'b0;
      fe_q      <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      dv_q      <= dv_d;
      fe_q      <= fe_d;
      brk_q     <= brk_d;
    end
  end

  // Next-state logic. Everything except the break exit advances on ticks only.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    dv_d      = 1'b0;
    fe_d      = 1'b0;
    brk_d     = brk_q;
    case (state_q)
      S_IDLE: begin
        if (tick16 && !rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (tick16) begin
          if (cnt_q == HALF_LAST) begin
            // Line high again at mid start bit: a glitch, not a frame.
            if (rx_s) begin
              state_d = S_IDLE;
            end else begin
              state_d   = S_DATA;
              cnt_d     = '0;
              bit_idx_d = '0;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_DATA: begin
        if (tick16) begin
          if (cnt_q == BIT_LAST) begin
            shift_d[bit_idx_q] = rx_s;
            cnt_d              = '0;
            if (bit_idx_q == IDX_LAST) begin
              state_d = S_STOP;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_STOP: begin
        if (tick16) begin
          if (cnt_q == BIT_LAST) begin
            cnt_d = '0;
            if (rx_s) begin
              data_d  = shift_q;
              dv_d    = 1'b1;
              state_d = S_IDLE;
            end else begin
              fe_d = 1'b1;
              // All data bits and the stop bit low: the line is in break.
              if (shift_q == 8'h00) begin
                brk_d = 1'b1;
              end
              state_d = S_BREAK;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_BREAK: begin
        // Hold off start detection until the line has been seen high.
        if (rx_s) begin
          brk_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    data_out   = data_q;
    data_valid = dv_q;
    frame_err  = fe_q;
    break_det  = brk_q;
    busy       = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_uart_rx_frontend.sv
module tb_uart_rx_frontend;

  localparam int OS = 16;
  localparam int DB = 8;

  logic       clk;
  logic       reset;
  logic       rx_in;
  logic       tick16;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       break_det;
  logic       busy;

  uart_rx_frontend #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_in      (rx_in),
    .tick16     (tick16),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .break_det  (break_det),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
    end
  endtask

  // Tick generator: every div-th clock, or random pulses in noise mode.
  int div       = 1;
  bit tick_rand = 1'b0;
  int tcnt      = 0;
  initial begin
    tick16 = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_rand) begin
        tick16 = ($urandom_range(0, 3) == 0);
      end else begin
        tcnt   = (tcnt + 1 >= div) ? 0 : tcnt + 1;
        tick16 = (tcnt == 0);
      end
    end
  end

  // Reference model: frame decoding written as a sequential walk over
  // tick-sampled line values (line seen through a 2-clock delay).
  logic [7:0] exp_data = 8'h00;
  logic       exp_dv   = 1'b0;
  logic       exp_fe   = 1'b0;
  logic       exp_brk  = 1'b0;
  logic       exp_busy = 1'b0;
  logic [1:0] sd       = 2'b11;
  bit         m_tick, m_rxs, m_rst, m_abort;
  logic [7:0] mb;

  task automatic m_edge();
    @(posedge clk);
    m_tick = tick16;
    m_rst  = reset;
    m_rxs  = sd[1];
    if (reset) sd = 2'b11;
    else       sd = {sd[0], rx_in};
    exp_dv = 1'b0;
    exp_fe = 1'b0;
    if (reset) begin
      exp_data = 8'h00;
      exp_brk  = 1'b0;
      exp_busy = 1'b0;
      m_abort  = 1'b1;
    end
  endtask

  task automatic m_ticks(input int n);
    int k;
    k = 0;
    while (k < n && !m_abort) begin
      m_edge();
      if (!m_abort && m_tick) k++;
    end
  endtask

  initial begin
    forever begin
      m_abort = 1'b0;
      do m_edge(); while (!m_abort && !(m_tick && !m_rxs));
      if (m_abort) continue;
      exp_busy = 1'b1;
      m_ticks(OS / 2);
      if (m_abort) continue;
      if (m_rxs) begin
        exp_busy = 1'b0;
        continue;
      end
      mb = 8'h00;
      for (int i = 0; i < DB; i++) begin
        m_ticks(OS);
        if (m_abort) break;
        mb[i] = m_rxs;
      end
      if (m_abort) continue;
      m_ticks(OS);
      if (m_abort) continue;
      if (m_rxs) begin
        exp_dv   = 1'b1;
        exp_data = mb;
        exp_busy = 1'b0;
      end else begin
        exp_fe = 1'b1;
        if (mb == 8'h00) exp_brk = 1'b1;
        do m_edge(); while (!m_abort && !m_rxs);
        if (m_abort) continue;
        exp_brk  = 1'b0;
        exp_busy = 1'b0;
      end
    end
  end

  // Compare process and event monitor, on the inactive clock edge.
  bit         check_en = 1'b0;
  int         cyc      = 0;
  logic [7:0] dv_q[$];
  int         dv_t[$];
  logic       dv_busy[$];
  int         fe_n     = 0;
  bit         brk_seen = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (check_en) begin
        chk("data_valid", data_valid, exp_dv);
        chk("frame_err",  frame_err,  exp_fe);
        chk("break_det",  break_det,  exp_brk);
        chk("busy",       busy,       exp_busy);
        chk("data_out",   data_out,   exp_data);
        if (data_valid) begin
          dv_q.push_back(data_out);
          dv_t.push_back(cyc);
          dv_busy.push_back(busy);
        end
        if (frame_err) fe_n++;
        if (break_det) brk_seen = 1'b1;
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic clr();
    dv_q.delete();
    dv_t.delete();
    dv_busy.delete();
    fe_n     = 0;
    brk_seen = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input bit b);
    rx_in = b;
    repeat (OS * div) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  initial begin
    reset = 1'b1;
    rx_in = 1'b1;
    repeat (2) @(negedge clk);
    check_en = 1'b1;
    chk("rst_data_out",   data_out,   8'h00);
    chk("rst_data_valid", data_valid, 1'b0);
    chk("rst_frame_err",  frame_err,  1'b0);
    chk("rst_break_det",  break_det,  1'b0);
    chk("rst_busy",       busy,       1'b0);
    reset = 1'b0;
    idle(10);

    // Single frame 0x55
    clr();
    send_frame(8'h55, 1'b1);
    idle(10);
    chk("f55_count", dv_q.size(), 1);
    if (dv_q.size() == 1) begin
      chk("f55_data", dv_q[0], 8'h55);
      chk("f55_busy_at_strobe", dv_busy[0], 1'b0);
    end
    chk("f55_fe", fe_n, 0);

    // Back-to-back 0xA3, 0x00
    clr();
    send_frame(8'hA3, 1'b1);
    send_frame(8'h00, 1'b1);
    idle(10);
    chk("b2b_count", dv_q.size(), 2);
    if (dv_q.size() == 2) begin
      chk("b2b_data0", dv_q[0], 8'hA3);
      chk("b2b_data1", dv_q[1], 8'h00);
      chk("b2b_spacing", dv_t[1] - dv_t[0], 160);
    end

    // Short glitch on idle line
    clr();
    rx_in = 1'b0;
    repeat (5) @(negedge clk);
    idle(20);
    chk("glitch_dv", dv_q.size(), 0);
    chk("glitch_fe", fe_n, 0);
    chk("glitch_busy", busy, 1'b0);

    // 0x41 with low stop bit
    clr();
    send_frame(8'h41, 1'b0);
    idle(20);
    chk("ferr_count", fe_n, 1);
    chk("ferr_dv", dv_q.size(), 0);
    chk("ferr_data_kept", data_out, 8'h00);
    chk("ferr_no_break", brk_seen, 1'b0);

    // Break: 30 bit times low
    clr();
    rx_in = 1'b0;
    repeat (30 * OS) @(negedge clk);
    chk("brk_level", break_det, 1'b1);
    chk("brk_fe", fe_n, 1);
    idle(6);
    chk("brk_cleared", break_det, 1'b0);
    chk("brk_busy", busy, 1'b0);
    send_frame(8'h7E, 1'b1);
    idle(10);
    chk("brk_next_count", dv_q.size(), 1);
    chk("brk_next_data", data_out, 8'h7E);

    // Reset during bit 4 of 0xFF
    clr();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx_in = 1'b1;
    repeat (OS / 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_data_out", data_out, 8'h00);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_break", break_det, 1'b0);
    reset = 1'b0;
    idle(4 * OS);
    chk("midrst_no_strobe", dv_q.size(), 0);
    send_frame(8'h12, 1'b1);
    idle(10);
    chk("midrst_next_data", data_out, 8'h12);

    // Randomised frames with varying tick rate
    for (int f = 0; f < 40; f++) begin
      logic [7:0] d;
      bit         stop;
      int         r;
      div  = $urandom_range(1, 3);
      r    = $urandom_range(0, 9);
      d    = (r == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      stop = (r > 1);
      if ($urandom_range(0, 7) == 0) begin
        rx_in = 1'b0;
        repeat ($urandom_range(1, OS * div / 2 - 1)) @(negedge clk);
        idle($urandom_range(1, 10));
      end
      send_frame(d, stop);
      idle($urandom_range(0, 40));
    end

    // Noise: random ticks, random line, occasional reset
    tick_rand = 1'b1;
    for (int n = 0; n < 150; n++) begin
      rx_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat ($urandom_range(1, 40)) @(negedge clk);
    end
    tick_rand = 1'b0;
    div       = 1;
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
